// File: rtl/ahb_xfer_scheduler.sv
// Shares one AHB master between a frame-read client and a result-write client, round-robin, one transaction in flight.
// Request issues 1 cycle after grant; clients are held off by rd_ready/wr_valid gating and the single-outstanding rule.
`timescale 1ns/1ps
module ahb_xfer_scheduler #(
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [31:0]      src_base,
    input  logic [31:0]      dst_base,
    input  logic [CNT_W-1:0] num_words,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    input  logic             wr_valid,
    input  logic [31:0]      wr_data,
    output logic             wr_accept,
    output logic             re,
    output logic             we,
    output logic [31:0]      mcu_raddr,
    output logic [31:0]      mcu_waddr,
    output logic [31:0]      buffer2_data,
    input  logic [31:0]      greyscale_data,
    input  logic             read_complete,
    input  logic             write_complete,
    output logic             busy,
    output logic             done,
    output logic             error
);
    typedef enum logic [2:0] {IDLE, ARB, WAIT_RD, WAIT_WR, ERR} state_t;
    localparam logic RR_READ  = 1'b0;
    localparam logic RR_WRITE = 1'b1;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d;
    logic [CNT_W-1:0] num_q, num_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic             rr_last_q, rr_last_d;
    logic [7:0]       wdog_q, wdog_d;
    logic             re_q, re_d, we_q, we_d, rd_valid_q, rd_valid_d, wr_accept_q, wr_accept_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [31:0]      raddr_q, raddr_d, waddr_q, waddr_d, wdata_q, wdata_d;
    logic             rd_elig, wr_elig, grant_rd;

    assign rd_elig  = (rd_cnt_q < num_q) && rd_ready;
    assign wr_elig  = (wr_cnt_q < num_q) && wr_valid;
    assign grant_rd = rd_elig && (!wr_elig || rr_last_q == RR_WRITE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            num_q       <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            rr_last_q   <= RR_WRITE;
            wdog_q      <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_accept_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            num_q       <= num_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rr_last_q   <= rr_last_d;
            wdog_q      <= wdog_d;
            re_q        <= re_d;
            we_q        <= we_d;
            rd_valid_q  <= rd_valid_d;
            wr_accept_q <= wr_accept_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        num_d       = num_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        rr_last_d   = rr_last_q;
        wdog_d      = wdog_q;
        re_d        = 1'b0;
        we_d        = 1'b0;
        rd_valid_d  = 1'b0;
        wr_accept_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    src_d    = src_base;
                    dst_d    = dst_base;
                    num_d    = num_words;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    error_d  = 1'b0;
                    if (num_words == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ARB;
                    end
                end
            end
            ARB: begin
                if (rd_elig || wr_elig) begin
                    wdog_d = '0;
                    if (grant_rd) begin
                        re_d    = 1'b1;
                        raddr_d = src_q + 32'(rd_cnt_q) * 32'(ADDR_STEP);
                        state_d = WAIT_RD;
                    end else begin
                        we_d        = 1'b1;
                        wr_accept_d = 1'b1;
                        waddr_d     = dst_q + 32'(wr_cnt_q) * 32'(ADDR_STEP);
                        wdata_d     = wr_data;
                        state_d     = WAIT_WR;
                    end
                end
            end
            WAIT_RD, WAIT_WR: begin
                if (state_q == WAIT_RD && read_complete) begin
                    rd_valid_d = 1'b1;
                    rd_cnt_d   = rd_cnt_q + 1'b1;
                    rr_last_d  = RR_READ;
                    state_d    = ARB;
                end else if (state_q == WAIT_WR && write_complete) begin
                    wr_cnt_d  = wr_cnt_q + 1'b1;
                    rr_last_d = RR_WRITE;
                    state_d   = ARB;
                end else if (wdog_q == 8'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ERR;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
                // Frame end resolves on the completing edge so done follows the last completion by one cycle
                if (state_d == ARB && rd_cnt_d == num_q && wr_cnt_d == num_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_data      = greyscale_data;
    assign rd_valid     = rd_valid_q;
    assign wr_accept    = wr_accept_q;
    assign re           = re_q;
    assign we           = we_q;
    assign mcu_raddr    = raddr_q;
    assign mcu_waddr    = waddr_q;
    assign buffer2_data = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
endmodule
